// File: rtl/ql_cycle_gen_pkg.sv
// Shared types and defaults for the QL cycle generator.
// duty_mask() gives the slot bits that must be zero for a CPU-owned phase.
package ql_cycle_pkg;

    typedef enum logic [1:0] {
        SPD_1X = 2'd0,
        SPD_2X = 2'd1,
        SPD_4X = 2'd2
    } speed_e;

    localparam int DEF_PHASE_W  = 3;
    localparam int DEF_SLOT_W   = 2;
    localparam int DEF_SD_DIV_W = 2;
    localparam int DEF_RTC_DIV  = 641;
    localparam int DEF_RST_LEN  = 4095;

    // A zero mask means every slot is CPU-owned.
    function automatic int unsigned duty_mask(input int unsigned spd, input int unsigned slot_w);
        if (spd >= slot_w) begin
            return 0;
        end
        return (32'd1 << (slot_w - spd)) - 32'd1;
    endfunction

endpackage

// File: rtl/ql_reset_stretch.sv
// Reset stretcher: reloads to LEN on any request, counts down on tick,
// and holds rst_out until the count has drained.
module ql_reset_stretch #(
    parameter int LEN = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic tick,
    output logic rst_out
);

    localparam int CNT_W = (LEN > 0) ? $clog2(LEN + 1) : 1;

    logic [CNT_W-1:0] rst_cnt;

    always_ff @(posedge clk) begin
        if (reset || req) begin
            rst_cnt <= CNT_W'(LEN);
        end else if (tick && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_out <= 1'b1;
        end else begin
            rst_out <= (rst_cnt != '0);
        end
    end

endmodule

// File: rtl/ql_cycle_gen.sv
// Clock-enable, CPU slot and stretched-reset generator for the QL core.
// Optional pause input/paused output are built when QL_CYCLE_GEN_PAUSE_EN is defined.
module ql_cycle_gen
    import ql_cycle_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int SD_DIV_W = DEF_SD_DIV_W,
    parameter int RTC_DIV  = DEF_RTC_DIV,
    parameter int RST_LEN  = DEF_RST_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_rst,
    input  logic [1:0] speed,
`ifdef QL_CYCLE_GEN_PAUSE_EN
    input  logic       pause,
    output logic       paused,
`endif
    output logic       ce_p,
    output logic       ce_n,
    output logic       ce_vid,
    output logic       ce_sd,
    output logic       ce_rtc,
    output logic       duty,
    output logic       sub_cycle,
    output logic       cpu_cycle,
    output logic       ce_bus_p,
    output logic       ce_bus_n,
    output logic [1:0] speed_cur,
    output logic       sys_reset
);

    localparam int DIV_W = PHASE_W + SLOT_W;
    localparam int HALF  = 1 << (PHASE_W - 1);
    localparam int RTC_W = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;

    logic [DIV_W-1:0]   div;
    logic [PHASE_W-1:0] ph;
    logic [SLOT_W-1:0]  slot;
    logic [RTC_W-1:0]   rtc_cnt;
    logic               phase_start;
    logic               window_start;
    logic [1:0]         spd_req;
    logic [1:0]         spd_next;
    logic               duty_calc;
    int unsigned        mask;

    assign ph           = div[PHASE_W-1:0];
    assign slot         = div[DIV_W-1:PHASE_W];
    assign phase_start  = (ph == '0);
    assign window_start = phase_start && (slot == '0);

    // Speed only changes at a window boundary, so duty never sees a partial window.
    always_comb begin
        spd_req = speed;
        if (int'(speed) > SLOT_W) begin
            spd_req = 2'(SLOT_W);
        end
        spd_next = window_start ? spd_req : speed_cur;
    end

`ifdef QL_CYCLE_GEN_PAUSE_EN
    logic paused_next;
    assign paused_next = window_start ? pause : paused;

    always_comb begin
        mask      = duty_mask(32'(spd_next), SLOT_W);
        duty_calc = ((32'(slot) & mask) == 0) && !paused_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            paused <= 1'b0;
        end else begin
            paused <= paused_next;
        end
    end
`else
    always_comb begin
        mask      = duty_mask(32'(spd_next), SLOT_W);
        duty_calc = ((32'(slot) & mask) == 0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            ce_p      <= 1'b0;
            ce_n      <= 1'b0;
            ce_vid    <= 1'b0;
            ce_sd     <= 1'b0;
            speed_cur <= 2'd0;
            sub_cycle <= 1'b0;
            duty      <= 1'b0;
        end else begin
            div       <= div + 1'b1;
            ce_p      <= phase_start;
            ce_n      <= (ph == PHASE_W'(HALF));
            ce_vid    <= phase_start;
            ce_sd     <= (div[SD_DIV_W-1:0] == '0);
            speed_cur <= spd_next;
            if (window_start) begin
                sub_cycle <= (spd_next == SPD_1X) ? ~sub_cycle : 1'b1;
            end
            if (phase_start) begin
                duty <= duty_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtc_cnt <= '0;
            ce_rtc  <= 1'b0;
        end else begin
            ce_rtc <= (rtc_cnt == '0);
            if (rtc_cnt == RTC_W'(RTC_DIV - 1)) begin
                rtc_cnt <= '0;
            end else begin
                rtc_cnt <= rtc_cnt + 1'b1;
            end
        end
    end

    assign cpu_cycle = duty & sub_cycle;
    assign ce_bus_p  = duty & ce_p;
    assign ce_bus_n  = duty & ce_n;

    ql_reset_stretch #(
        .LEN(RST_LEN)
    ) u_rst (
        .clk    (clk),
        .reset  (reset),
        .req    (ext_rst),
        .tick   (ce_p),
        .rst_out(sys_reset)
    );

endmodule
